ad7656_sample_scheduler: RTL
============================

// Module: ad7656_sample_scheduler
// PURPOSE
//  Issues timed conversion-start pulses to ADC_NUM AD7656 read drivers (the static and vibration channels).
//  One programmable period and one phase offset per ADC; a common sync realigns all ADCs.
//  Each ADC is tracked from start to convst_done; overruns, optional timeouts and completed samples are counted.
//  Sits between the register/config block and the AD7656 wrapper's start_flag inputs.
// PARAMETERS
//  ADC_NUM      2        number of scheduled ADCs
//  PER_W        24       width of period/phase fields, in sys_clk cycles
//  MIN_PERIOD   200      smallest legal period; smaller programmed values are clamped up to this
//  CNT_W        16       width of each sample counter (wraps)
//  TIMEOUT_CYC  4096     BUSY watchdog limit in cycles (only with the macro)
// PORTS
//  sys_clk_i      in   1               system clock; all logic on rising edge
//  rst_n_i        in   1               asynchronous active-low reset
//  cfg_en_i       in   ADC_NUM         per-ADC enable (level)
//  cfg_period_i   in   ADC_NUM*PER_W   per-ADC period, in cycles
//  cfg_phase_i    in   ADC_NUM*PER_W   per-ADC first-tick delay after enable or sync
//  sync_i         in   1               one-cycle pulse; reloads the phase of every enabled ADC
//  convst_done_i  in   ADC_NUM         one-cycle done pulse from each read driver
//  ovr_clr_i      in   ADC_NUM         one-cycle clear of the sticky overrun/timeout bits
//  start_flag_o   out  ADC_NUM         one-cycle start pulse to each read driver
//  busy_o         out  ADC_NUM         conversion outstanding (BUSY state)
//  overrun_o      out  ADC_NUM         sticky: a tick arrived while BUSY
//  timeout_o      out  ADC_NUM         sticky: BUSY watchdog expired (tied 0 without the macro)
//  sample_cnt_o   out  ADC_NUM*CNT_W   completed-sample counters
// BEHAVIOUR
//  Reset: all outputs are 0, counters are 0, state is IDLE.
//  Per-ADC down-counter cnt:
//    - Rising edge of cfg_en_i[k], or sync_i while enabled: cnt <= phase.
//    - Otherwise, while enabled: cnt==0 raises tick, and cnt <= eff_period-1; else cnt <= cnt-1.
//    - eff_period = max(cfg_period, MIN_PERIOD), sampled at each reload, so a new period takes effect on the next wrap.
//    - phase==0 gives a tick on the cycle after the load.
//  Start latency: start_flag_o is registered and high exactly one cycle after tick.
//  FSM per ADC:
//    - IDLE: tick causes a start pulse and moves to BUSY.
//    - BUSY: convst_done_i moves to IDLE and increments sample_cnt (wraps at 2^CNT_W).
//    - BUSY: a tick causes no start pulse; overrun_o is set and the state stays BUSY.
//    - Tick and done in the same cycle while BUSY: done is processed first; the tick is treated as arriving in IDLE, so a start is issued with no overrun.
//    - convst_done_i while in IDLE is ignored; no count.
//  Disable (cfg_en_i falls) during BUSY:
//    - No further ticks; cnt holds at 0.
//    - The outstanding conversion still completes and is counted.
//  sync_i coinciding with tick: sync wins; cnt reloads phase and no start is issued that cycle.
//  Sticky bits: set and ovr_clr_i in the same cycle leaves the bit SET.
//  ADCs are fully independent; each ADC has exactly one outstanding start at most.
// CONFIGURATION
//  Macro AD7656_SCHED_TIMEOUT_EN:
//    - Defined: a BUSY-cycle counter runs; at TIMEOUT_CYC cycles it sets timeout_o and forces IDLE without counting a sample. A later done is ignored.
//    - Undefined: no watchdog logic; timeout_o = 0; BUSY waits indefinitely.
// STRUCTURE
//  Package ad7656_sched_pkg:
//    - sched_state_t enum {IDLE, BUSY}
//    - defaults for PER_W, CNT_W, MIN_PERIOD, TIMEOUT_CYC
//    - clamp function for eff_period
//  Sub-module ad7656_sched_chan: one ADC's counter, FSM, sticky bits and sample counter; generated ADC_NUM times.
//  The top level handles only fan-out of sync_i and field slicing.
// TESTING
//  1. period=1000, phase=0, enable ADC0; done 5 cycles after each start
//     -> starts 1 cycle after enable+1, then every 1000 cycles; sample_cnt increments; no overrun.
//  2. period=300, done withheld for 400 cycles
//     -> second tick sets overrun_o[0] with no start; ovr_clr_i clears it.
//  3. phase0=0, phase1=500, sync_i pulse
//     -> ADC1 start exactly 500 cycles after ADC0 start.
//  4. period=50 (below MIN_PERIOD)
//     -> starts spaced 200 cycles.
//  5. disable while BUSY, then done
//     -> sample_cnt +1, no further start_flag_o.
//  6. macro defined, done never returned
//     -> timeout_o set at 4096 cycles, busy_o=0, next tick issues a start.

Source files
------------

// File: rtl/ad7656_sched_pkg.sv
`default_nettype none
// ============================================================================
// Package : ad7656_sched_pkg
// Brief   : Shared types, parameter defaults and period clamp for the AD7656
//           sample scheduler.
// Rev     : 1.0
// ============================================================================
package ad7656_sched_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sched_state_t;

  localparam int c_def_per_w       = 24;
  localparam int c_def_cnt_w       = 16;
  localparam int c_def_min_period  = 200;
  localparam int c_def_timeout_cyc = 4096;

  // Programmed periods below the floor are raised to it, never rejected.
  function automatic logic [31:0] clamp_period(input logic [31:0] period,
                                               input logic [31:0] min_period);
    return (period < min_period) ? min_period : period;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ad7656_sched_chan.sv
`default_nettype none
// ============================================================================
// Module  : ad7656_sched_chan
// Brief   : One ADC channel: phase/period down-counter, IDLE/BUSY tracker,
//           sticky overrun/timeout bits and completed-sample counter.
//           Watchdog built only when AD7656_SCHED_TIMEOUT_EN is defined.
// Rev     : 1.0
// ============================================================================
module ad7656_sched_chan
  import ad7656_sched_pkg::*;
#(
  parameter int PER_W       = c_def_per_w,
  parameter int CNT_W       = c_def_cnt_w,
  parameter int MIN_PERIOD  = c_def_min_period,
  parameter int TIMEOUT_CYC = c_def_timeout_cyc
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [PER_W-1:0] i_period,
  input  logic [PER_W-1:0] i_phase,
  input  logic             i_sync,
  input  logic             i_done,
  input  logic             i_ovr_clr,
  output logic             o_start,
  output logic             o_busy,
  output logic             o_overrun,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_sample_cnt
);

  localparam logic [PER_W-1:0] c_per_one = PER_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  sched_state_t     r_state;
  sched_state_t     w_state_nxt;
  logic             r_en_q;
  logic [PER_W-1:0] r_cnt;
  logic             r_start;
  logic             r_overrun;
  logic [CNT_W-1:0] r_sample_cnt;

  logic             w_rise;
  logic             w_reload;
  logic             w_tick;
  logic             w_expire;
  logic             w_start_nxt;
  logic             w_ovr_set;
  logic             w_count;
  logic [31:0]      w_eff_period;
  logic [PER_W-1:0] w_wrap_val;

  // A reload (enable edge or sync) suppresses any tick in the same cycle.
  assign w_rise       = i_en & ~r_en_q;
  assign w_reload     = w_rise | (i_sync & i_en);
  assign w_tick       = i_en & ~w_reload & (r_cnt == '0);
  assign w_eff_period = clamp_period(32'(i_period), 32'(MIN_PERIOD));
  assign w_wrap_val   = PER_W'(w_eff_period - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_q <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_en_q <= i_en;
      if (w_reload) begin
        r_cnt <= i_phase;
      end else if (i_en) begin
        r_cnt <= w_tick ? w_wrap_val : (r_cnt - c_per_one);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Completion (done or watchdog) is resolved before a coincident tick.
  always_comb begin
    w_state_nxt = r_state;
    w_start_nxt = 1'b0;
    w_ovr_set   = 1'b0;
    w_count     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tick) begin
          w_start_nxt = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (i_done) begin
          w_count     = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_expire) begin
          w_state_nxt = IDLE;
        end
        if (w_tick) begin
          if (i_done || w_expire) begin
            w_start_nxt = 1'b1;
            w_state_nxt = BUSY;
          end else begin
            w_ovr_set = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start      <= 1'b0;
      r_overrun    <= 1'b0;
      r_sample_cnt <= '0;
    end else begin
      r_start   <= w_start_nxt;
      r_overrun <= (r_overrun & ~i_ovr_clr) | w_ovr_set;
      if (w_count) begin
        r_sample_cnt <= r_sample_cnt + c_cnt_one;
      end
    end
  end

`ifdef AD7656_SCHED_TIMEOUT_EN
  localparam int               c_bc_w     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_bc_w-1:0] c_bc_one  = c_bc_w'(1);
  localparam logic [c_bc_w-1:0] c_to_last = c_bc_w'(TIMEOUT_CYC - 1);

  logic [c_bc_w-1:0] r_busy_cnt;
  logic              r_timeout;

  // BUSY lasts at most TIMEOUT_CYC cycles; the counter restarts on every start.
  assign w_expire = (r_state == BUSY) & ~i_done & (r_busy_cnt == c_to_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if ((r_state == BUSY) && (w_state_nxt == BUSY) && !w_start_nxt) begin
        r_busy_cnt <= r_busy_cnt + c_bc_one;
      end else begin
        r_busy_cnt <= '0;
      end
      r_timeout <= (r_timeout & ~i_ovr_clr) | w_expire;
    end
  end

  assign o_timeout = r_timeout;
`else
  logic w_unused_timeout_cfg;

  assign w_unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign w_expire             = 1'b0;
  assign o_timeout            = 1'b0;
`endif

  assign o_start      = r_start;
  assign o_busy       = (r_state == BUSY);
  assign o_overrun    = r_overrun;
  assign o_sample_cnt = r_sample_cnt;

endmodule
`default_nettype wire

// File: rtl/ad7656_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : ad7656_sample_scheduler
// Brief   : Timed conversion-start scheduler for ADC_NUM AD7656 read drivers;
//           fans out sync and slices per-ADC config. BUSY watchdog enabled by
//           defining AD7656_SCHED_TIMEOUT_EN.
// Rev     : 1.0
// ============================================================================
module ad7656_sample_scheduler
  import ad7656_sched_pkg::*;
#(
  parameter int ADC_NUM     = 2,
  parameter int PER_W       = c_def_per_w,
  parameter int MIN_PERIOD  = c_def_min_period,
  parameter int CNT_W       = c_def_cnt_w,
  parameter int TIMEOUT_CYC = c_def_timeout_cyc
) (
  input  logic                     sys_clk_i,
  input  logic                     rst_n_i,
  input  logic [ADC_NUM-1:0]       cfg_en_i,
  input  logic [ADC_NUM*PER_W-1:0] cfg_period_i,
  input  logic [ADC_NUM*PER_W-1:0] cfg_phase_i,
  input  logic                     sync_i,
  input  logic [ADC_NUM-1:0]       convst_done_i,
  input  logic [ADC_NUM-1:0]       ovr_clr_i,
  output logic [ADC_NUM-1:0]       start_flag_o,
  output logic [ADC_NUM-1:0]       busy_o,
  output logic [ADC_NUM-1:0]       overrun_o,
  output logic [ADC_NUM-1:0]       timeout_o,
  output logic [ADC_NUM*CNT_W-1:0] sample_cnt_o
);

  for (genvar k = 0; k < ADC_NUM; k++) begin : g_chan
    ad7656_sched_chan #(
      .PER_W       (PER_W),
      .CNT_W       (CNT_W),
      .MIN_PERIOD  (MIN_PERIOD),
      .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_chan (
      .clk          (sys_clk_i),
      .rst_n        (rst_n_i),
      .i_en         (cfg_en_i[k]),
      .i_period     (cfg_period_i[k*PER_W +: PER_W]),
      .i_phase      (cfg_phase_i[k*PER_W +: PER_W]),
      .i_sync       (sync_i),
      .i_done       (convst_done_i[k]),
      .i_ovr_clr    (ovr_clr_i[k]),
      .o_start      (start_flag_o[k]),
      .o_busy       (busy_o[k]),
      .o_overrun    (overrun_o[k]),
      .o_timeout    (timeout_o[k]),
      .o_sample_cnt (sample_cnt_o[k*CNT_W +: CNT_W])
    );
  end

endmodule
`default_nettype wire
